// File: rtl/fm_demodulator.sv
// fm_demodulator: FM quadrature demodulator; phase step between successive complex Q10 samples
// via a fixed-point arctangent, scaled by the demodulation gain, buffered by three FWFT FIFOs.
module fm_fifo #(
  parameter int W = 32,
  parameter int D = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         wr_en,
  input  logic [W-1:0] din,
  output logic         full,
  input  logic         rd_en,
  output logic [W-1:0] dout,
  output logic         empty
);
  localparam int A = (D > 1) ? $clog2(D) : 1;
  localparam int DM = D - 1;
  localparam logic [A-1:0] LAST = DM[A-1:0];
  localparam logic [A:0] FULL_CNT = D[A:0];
  logic [W-1:0] mem [D];
  logic [A-1:0] wp, rp;
  logic [A:0] cnt, cnt_nx;
  logic do_wr, do_rd;
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;
  assign cnt_nx = cnt + {{A{1'b0}}, do_wr} - {{A{1'b0}}, do_rd};
  assign dout = mem[rp];
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      mem <= '{default: '0};
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      full <= 1'b0;
      empty <= 1'b1;
    end else begin
      if (do_wr) mem[wp] <= din;
      wp <= do_wr ? ((wp == LAST) ? '0 : wp + 1'b1) : wp;
      rp <= do_rd ? ((rp == LAST) ? '0 : rp + 1'b1) : rp;
      cnt <= cnt_nx;
      full <= cnt_nx == FULL_CNT;
      empty <= cnt_nx == '0;
    end
endmodule

module fm_demodulator #(
  parameter int DATA_SIZE  = 32,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [DATA_SIZE-1:0] real_in,
  input  logic                 real_wr_en,
  output logic                 real_full,
  input  logic [DATA_SIZE-1:0] imag_in,
  input  logic                 imag_wr_en,
  output logic                 imag_full,
  output logic [DATA_SIZE-1:0] data_out,
  input  logic                 data_out_rd_en,
  output logic                 data_out_empty
);
  localparam int W = DATA_SIZE;
  localparam int W2 = 2 * DATA_SIZE;
  localparam int CW = $clog2(DATA_SIZE);
  localparam logic signed [W-1:0] Q1 = W'(804);
  localparam logic signed [W-1:0] Q3 = W'(2412);
  localparam logic signed [W-1:0] GAIN = W'(758);
  typedef enum logic [2:0] {S_IDLE, S_MULT, S_PREP, S_DIV, S_FIN, S_GAIN, S_WRITE} state_t;
  state_t state, state_nx;
  logic pop, push, real_empty, imag_empty, out_full;
  logic [W-1:0] real_head, imag_head, result;
  logic signed [W-1:0] prev_r, prev_i, cur_r, cur_i, re, im, angle;
  logic signed [W-1:0] ay, diff, num, den, q, ang0;
  logic signed [W2-1:0] re_sum, im_sum;
  logic x_neg, y_neg, q_neg, ge;
  logic [W-1:0] dq, dvs, rem, rem_nx;
  logic [W:0] rem_sh;
  logic [CW-1:0] cnt;

  // Divide by 1024 truncating toward zero: bias negatives before the arithmetic shift.
  function automatic logic signed [W-1:0] deq(input logic signed [W2-1:0] v);
    logic signed [W2-1:0] t;
    t = v[W2-1] ? v + W2'(1023) : v;
    return W'(t >>> 10);
  endfunction

  fm_fifo #(.W(W), .D(FIFO_DEPTH)) u_real (
    .clock(clock), .reset(reset), .wr_en(real_wr_en), .din(real_in), .full(real_full),
    .rd_en(pop), .dout(real_head), .empty(real_empty));
  fm_fifo #(.W(W), .D(FIFO_DEPTH)) u_imag (
    .clock(clock), .reset(reset), .wr_en(imag_wr_en), .din(imag_in), .full(imag_full),
    .rd_en(pop), .dout(imag_head), .empty(imag_empty));
  fm_fifo #(.W(W), .D(FIFO_DEPTH)) u_out (
    .clock(clock), .reset(reset), .wr_en(push), .din(result), .full(out_full),
    .rd_en(data_out_rd_en), .dout(data_out), .empty(data_out_empty));

  assign re_sum = W2'(prev_r) * W2'(cur_r) + W2'(prev_i) * W2'(cur_i);
  assign im_sum = W2'(prev_r) * W2'(cur_i) - W2'(prev_i) * W2'(cur_r);
  assign ay = (im[W-1] ? -im : im) + W'(1);
  assign diff = re[W-1] ? re + ay : re - ay;
  assign num = diff <<< 10;
  assign den = re[W-1] ? ay - re : re + ay;
  assign q = q_neg ? -dq : dq;
  assign ang0 = (x_neg ? Q3 : Q1) - deq(W2'(q) * W2'(Q1));
  // Restoring divider on magnitudes; the quotient sign is reapplied afterwards.
  assign rem_sh = {rem, dq[W-1]};
  assign ge = rem_sh >= {1'b0, dvs};
  assign rem_nx = ge ? W'(rem_sh - {1'b0, dvs}) : rem_sh[W-1:0];

  always_ff @(posedge clock or negedge reset)
    if (!reset) state <= S_IDLE;
    else state <= state_nx;

  always_comb begin
    state_nx = state;
    pop = 1'b0;
    push = 1'b0;
    case (state)
      S_IDLE: if (!real_empty && !imag_empty) begin
        pop = 1'b1;
        state_nx = S_MULT;
      end
      S_MULT: state_nx = S_PREP;
      S_PREP: state_nx = S_DIV;
      S_DIV: state_nx = (cnt == '1) ? S_FIN : S_DIV;
      S_FIN: state_nx = S_GAIN;
      S_GAIN: state_nx = S_WRITE;
      S_WRITE: if (!out_full) begin
        push = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      {prev_r, prev_i, cur_r, cur_i, re, im, angle, result} <= '0;
      {dq, dvs, rem, cnt, x_neg, y_neg, q_neg} <= '0;
    end else
      case (state)
        S_IDLE: if (pop) begin
          cur_r <= real_head;
          cur_i <= imag_head;
        end
        S_MULT: begin
          re <= deq(re_sum);
          im <= deq(im_sum);
          prev_r <= cur_r;
          prev_i <= cur_i;
        end
        S_PREP: begin
          x_neg <= re[W-1];
          y_neg <= im[W-1];
          q_neg <= num[W-1];
          dq <= num[W-1] ? -num : num;
          dvs <= den;
          rem <= '0;
          cnt <= '0;
        end
        S_DIV: begin
          rem <= rem_nx;
          dq <= {dq[W-2:0], ge};
          cnt <= cnt + 1'b1;
        end
        S_FIN: angle <= y_neg ? -ang0 : ang0;
        S_GAIN: result <= deq(W2'(angle) * W2'(GAIN));
        default: ;
      endcase
endmodule

// File: tb/tb_fm_demodulator.sv
// tb_fm_demodulator: directed checks of the FM demodulator plus a 1000-sample stream against a reference model.
module tb_fm_demodulator;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [31:0] real_in = '0, imag_in = '0, data_out;
  logic real_wr_en = 1'b0, imag_wr_en = 1'b0, data_out_rd_en = 1'b0;
  logic real_full, imag_full, data_out_empty;
  int vectors = 0, miscompares = 0;
  int stim_r [1000], stim_i [1000], golden [1000];

  always #5 clock = ~clock;

  fm_demodulator #(.DATA_SIZE(32), .FIFO_DEPTH(16)) dut (
    .clock(clock), .reset(reset),
    .real_in(real_in), .real_wr_en(real_wr_en), .real_full(real_full),
    .imag_in(imag_in), .imag_wr_en(imag_wr_en), .imag_full(imag_full),
    .data_out(data_out), .data_out_rd_en(data_out_rd_en), .data_out_empty(data_out_empty));

  function automatic int deq(longint v);
    return int'(v / 1024);
  endfunction

  function automatic int model(int pr, int pi, int cr, int ci);
    int re, im, ay, num, den, q, ang;
    re = deq(longint'(pr) * cr + longint'(pi) * ci);
    im = deq(longint'(pr) * ci - longint'(pi) * cr);
    ay = (im < 0 ? -im : im) + 1;
    if (re >= 0) begin
      num = (re - ay) * 1024;
      den = re + ay;
    end else begin
      num = (re + ay) * 1024;
      den = ay - re;
    end
    q = num / den;
    ang = (re >= 0 ? 804 : 2412) - deq(longint'(804) * q);
    if (im < 0) ang = -ang;
    return deq(longint'(758) * ang);
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    real_wr_en = 0;
    imag_wr_en = 0;
    data_out_rd_en = 0;
    reset = 0;
    tick();
    reset = 1;
    tick();
  endtask

  task automatic push_pair(input logic [31:0] r, input logic [31:0] i);
    real_in = r;
    imag_in = i;
    real_wr_en = 1;
    imag_wr_en = 1;
    tick();
    real_wr_en = 0;
    imag_wr_en = 0;
  endtask

  task automatic wait_out(output int cyc);
    cyc = 0;
    while (data_out_empty && cyc < 100) begin
      tick();
      cyc++;
    end
  endtask

  task automatic pop();
    data_out_rd_en = 1;
    tick();
    data_out_rd_en = 0;
  endtask

  task automatic run_two(input logic [31:0] r, input logic [31:0] i,
                         output logic [31:0] o1, output logic [31:0] o2, output bit ok);
    int c;
    do_reset();
    push_pair(32'h400, 32'h0);
    wait_out(c);
    ok = !data_out_empty;
    o1 = data_out;
    pop();
    push_pair(r, i);
    wait_out(c);
    ok = ok && !data_out_empty;
    o2 = data_out;
    pop();
  endtask

  task automatic test_reset();
    tick();
    tick();
    #2 reset = 0;
    #1;
    vectors++;
    if (data_out_empty !== 1'b1) begin miscompares++; $display("FAIL reset_empty: got %b expected 1", data_out_empty); end
    vectors++;
    if (real_full !== 1'b0) begin miscompares++; $display("FAIL reset_real_full: got %b expected 0", real_full); end
    vectors++;
    if (imag_full !== 1'b0) begin miscompares++; $display("FAIL reset_imag_full: got %b expected 0", imag_full); end
    vectors++;
    if (data_out !== 32'h0) begin miscompares++; $display("FAIL reset_data_out: got %h expected 00000000", data_out); end
    tick();
    reset = 1;
    tick();
  endtask

  task automatic test_first_sample();
    int cyc;
    do_reset();
    push_pair(32'h400, 32'h0);
    wait_out(cyc);
    vectors++;
    if (data_out_empty || data_out !== 32'h000004A6) begin
      miscompares++;
      $display("FAIL first_sample: got %h (empty=%b) expected 000004a6", data_out, data_out_empty);
    end
    vectors++;
    if (cyc > 45) begin miscompares++; $display("FAIL latency: got %0d cycles expected <= 45", cyc); end
    pop();
    tick();
    vectors++;
    if (data_out_empty !== 1'b1) begin miscompares++; $display("FAIL pop_empty: got %b expected 1", data_out_empty); end
  endtask

  task automatic test_zero_step();
    logic [31:0] o1, o2;
    bit ok;
    run_two(32'h400, 32'h0, o1, o2, ok);
    vectors++;
    if (!ok || o1 !== 32'h000004A6) begin miscompares++; $display("FAIL zero_step_first: got %h expected 000004a6", o1); end
    vectors++;
    if (!ok || o2 !== 32'h00000001) begin miscompares++; $display("FAIL zero_step: got %h expected 00000001", o2); end
  endtask

  task automatic test_pos90();
    logic [31:0] o1, o2;
    bit ok;
    run_two(32'h0, 32'h400, o1, o2, ok);
    vectors++;
    if (!ok || o2 !== 32'h000004A6) begin miscompares++; $display("FAIL pos90_step: got %h expected 000004a6", o2); end
  endtask

  task automatic test_neg90();
    logic [31:0] o1, o2;
    bit ok;
    run_two(32'h0, 32'hFFFFFC00, o1, o2, ok);
    vectors++;
    if (!ok || o2 !== 32'hFFFFFB5A) begin miscompares++; $display("FAIL neg90_step: got %h expected fffffb5a", o2); end
  endtask

  task automatic test_reset_abort();
    int cyc;
    do_reset();
    push_pair(32'h400, 32'h400);
    repeat (10) tick();
    #2 reset = 0;
    tick();
    reset = 1;
    repeat (60) tick();
    vectors++;
    if (data_out_empty !== 1'b1) begin miscompares++; $display("FAIL abort_no_output: empty got %b expected 1", data_out_empty); end
    push_pair(32'h400, 32'h0);
    wait_out(cyc);
    vectors++;
    if (data_out_empty || data_out !== 32'h000004A6) begin
      miscompares++;
      $display("FAIL abort_prev_cleared: got %h expected 000004a6", data_out);
    end
    pop();
  endtask

  task automatic test_stream();
    int pr, pi, w;
    bit abort;
    pr = 0;
    pi = 0;
    abort = 0;
    for (int k = 0; k < 1000; k++) begin
      stim_r[k] = int'($urandom_range(4095)) - 2048;
      stim_i[k] = int'($urandom_range(4095)) - 2048;
      golden[k] = model(pr, pi, stim_r[k], stim_i[k]);
      pr = stim_r[k];
      pi = stim_i[k];
    end
    do_reset();
    fork
      begin
        int pw;
        for (int k = 0; k < 1000 && !abort; k++) begin
          pw = 0;
          while ((real_full || imag_full) && pw < 3000) begin
            tick();
            pw++;
          end
          if (pw >= 3000) begin
            vectors++;
            miscompares++;
            $display("FAIL stream_producer: input stayed full at sample %0d", k);
            abort = 1;
          end else push_pair(stim_r[k], stim_i[k]);
        end
      end
      begin
        repeat (800) tick();
        vectors++;
        if (real_full !== 1'b1) begin miscompares++; $display("FAIL stream_real_full: got %b expected 1", real_full); end
        vectors++;
        if (imag_full !== 1'b1) begin miscompares++; $display("FAIL stream_imag_full: got %b expected 1", imag_full); end
        for (int k = 0; k < 1000 && !abort; k++) begin
          wait_out(w);
          vectors++;
          if (data_out_empty) begin
            miscompares++;
            $display("FAIL stream_timeout: no output for sample %0d", k);
            abort = 1;
          end else begin
            if (data_out !== golden[k]) begin
              miscompares++;
              $display("FAIL stream_sample %0d: got %h expected %h", k, data_out, golden[k]);
            end
            pop();
          end
        end
      end
    join
    repeat (60) tick();
    vectors++;
    if (data_out_empty !== 1'b1) begin miscompares++; $display("FAIL stream_extra_output: got %h expected empty", data_out); end
  endtask

  initial begin
    test_reset();
    test_first_sample();
    test_zero_step();
    test_pos90();
    test_neg90();
    test_reset_abort();
    test_stream();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/fm_demodulator.md
# fm_demodulator

FM quadrature demodulator for the FM radio pipeline. It receives complex baseband samples (real and imaginary, Q10 fixed point) from the channel FIR through two input FIFOs. For each sample it computes the phase difference against the previous sample with a fixed-point arctangent, scales the result by the demodulation gain, and pushes one 32-bit word per input pair into an output FIFO. The downstream audio filters read from that FIFO.

## Interface

Parameters:
- DATA_SIZE, 32: sample word width, signed two's complement, Q10.
- FIFO_DEPTH, 16: depth of each of the three internal FIFOs, in words.

Ports:
- clock, input, 1: rising-edge clock.
- reset, input, 1: asynchronous, active-low.
- real_in, input, DATA_SIZE: real sample to write.
- real_wr_en, input, 1: pushes real_in into the real FIFO.
- real_full, output, 1: real FIFO full.
- imag_in, input, DATA_SIZE: imaginary sample to write.
- imag_wr_en, input, 1: pushes imag_in into the imag FIFO.
- imag_full, output, 1: imag FIFO full.
- data_out, output, DATA_SIZE: head of the output FIFO (first-word fall-through).
- data_out_rd_en, input, 1: pops the output FIFO.
- data_out_empty, output, 1: output FIFO empty.

## Operation

Constants:
- QUANT = 1024 (Q10).
- GAIN = 758.
- Q1 = 804 (π/4).
- Q3 = 2412 (3π/4).

DEQ(v) means v / 1024, signed, truncated toward zero (not an arithmetic shift).

Core state machine:
- IDLE: proceed when the real FIFO and imag FIFO are both non-empty. Pop one word from each; the pops happen in the same cycle.
- MULT: compute the differential products.
  - re = DEQ(prev_r·cur_r + prev_i·cur_i)
  - im = DEQ(prev_r·cur_i − prev_i·cur_r)
  - Products and sums are 64-bit signed; keep the low 32 bits after DEQ.
  - Update prev_r, prev_i ← cur_r, cur_i.
- ATAN_PREP: let x = re and y = im.
  - ay = |y| + 1.
  - If x ≥ 0: num = (x − ay)·1024 and den = x + ay.
  - Else: num = (x + ay)·1024 and den = ay − x.
  - All values are 32-bit. den is always ≥ 1.
- DIV: q = num / den, signed 32-bit, truncated toward zero. Iterative or pipelined, at most 34 cycles.
- ATAN_FIN:
  - angle = base − DEQ(Q1·q), where base is Q1 if x ≥ 0, else Q3.
  - If y < 0, angle = −angle.
- GAIN: result = DEQ(GAIN·angle).
- WRITE: when the output FIFO is not full, push result and return to IDLE. Otherwise stall in WRITE.

Behaviour:
- prev_r and prev_i are 0 after reset.
- The output stream is bit-exact to the C reference model using these formulas.
- Input and output FIFOs are independent. Writes while full are ignored, and the writer must respect the full flag. Reads while empty are ignored, and data_out is undefined in that case.
- The real and imag FIFOs are written in lockstep by the producer. The core never pops one without the other.

## Timing

Reset (asynchronous) clears:
- all FIFO contents and pointers;
- prev_r and prev_i;
- the state machine (to IDLE);
- all intermediate registers.

After reset: real_full = 0, imag_full = 0, data_out_empty = 1, data_out = 0.

FIFOs:
- Synchronous write and read on the clock edge.
- Full and empty are registered and update on the edge after the push or pop.
- A simultaneous push and pop on a non-empty, non-full FIFO keeps the count unchanged.
- Pointers wrap modulo FIFO_DEPTH.

Throughput and latency:
- Throughput is at least one sample per 40 cycles with no output backpressure.
- Latency from an input word landing in the FIFO to the result being visible at data_out is at most 45 cycles.

Output handshake:
- data_out is valid whenever data_out_empty = 0.
- Asserting data_out_rd_en in a cycle consumes that word. The next word appears on the following edge.

Reset asserted mid-computation aborts the current sample, and no partial result is written.

## Test plan

All samples are applied with the real and imag writes in the same cycle.
- **Reset:** assert reset -> data_out_empty = 1, real_full = 0, imag_full = 0.
- **First sample, prev = 0:** write (r, i) = (0x400, 0x0) -> data_out = 0x000004A6 (re = im = 0, angle 1608, result 1190).
- **Zero phase step:** write (0x400, 0) then (0x400, 0) -> second output = 0x00000001.
- **+90° step:** write (0x400, 0) then (0, 0x400) -> second output = 0x000004A6.
- **−90° step:** write (0x400, 0) then (0, 0xFFFFFC00) -> second output = 0xFFFFFB5A (sign handling, truncation toward zero).
- **Streaming with backpressure:** stream 1000 FIR output pairs while holding data_out_rd_en low long enough for the FIFOs to fill, then drain. Required: real_full and imag_full assert; no samples are lost; exactly 1000 outputs, all matching the golden file.
